// File: rtl/ctrl_clk_pkg.sv
// ctrl_clk_pkg: lock FSM states and default rates shared by the control-clock divider and meter.
package ctrl_clk_pkg;
   typedef enum logic [1:0] {UNLOCK, ACQ, LOCKED} state_t;
   localparam int DEF_CNT_W        = 12;
   localparam int DEF_NOMINAL_HALF = 501;
   localparam int DEF_TOL          = 4;
   localparam int DEF_LOCK_CNT     = 4;
   localparam int DEF_TIMEOUT      = 1503;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous input, plus edge detection against a delayed copy.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);
   logic r_s1, r_s2, r_prev;
   always_ff @(posedge clk) begin
      if (rst) {r_s1, r_s2, r_prev} <= '0;
      else     {r_s1, r_s2, r_prev} <= {i_async, r_s1, r_s2};
   end
   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_prev;
   assign o_fall  = ~r_s2 & r_prev;
endmodule

// File: rtl/ctrl_clk_meter.sv
// ctrl_clk_meter: measures control-clock half-periods in clk cycles and tracks lock/timeout.
module ctrl_clk_meter
   import ctrl_clk_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int NOMINAL_HALF = DEF_NOMINAL_HALF,
   parameter int TOL          = DEF_TOL,
   parameter int LOCK_CNT     = DEF_LOCK_CNT,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_clk_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic [7:0]       err_cnt
);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W:0]   MEAS_LO = (CNT_W+1)'(NOMINAL_HALF - TOL);
   localparam logic [CNT_W:0]   MEAS_HI = (CNT_W+1)'(NOMINAL_HALF + TOL);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

   logic              w_level, w_rise, w_fall, w_edge, w_match, w_tmo, w_err_inc;
   logic [CNT_W:0]    w_meas;
   logic [GOOD_W-1:0] w_good_inc, w_good_nxt;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [GOOD_W-1:0] r_good;
   logic              r_have;
   state_t            r_state;

   sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (ctrl_clk_in),
      .o_level (w_level),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_edge     = w_rise | w_fall;
   assign w_meas     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_match    = (w_meas >= MEAS_LO) && (w_meas <= MEAS_HI);
   assign w_tmo      = !w_edge && (r_cnt == TMO);
   assign w_good_inc = r_good + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_err_inc   = 1'b0;
      if (w_tmo) begin
         w_state_nxt = UNLOCK;
         w_good_nxt  = '0;
      end else if (w_edge) begin
         case (r_state)
            UNLOCK: begin
               w_state_nxt = ACQ;
               w_good_nxt  = '0;
            end
            ACQ: begin
               w_good_nxt  = w_match ? w_good_inc : '0;
               w_state_nxt = (w_match && w_good_inc == GOOD_W'(LOCK_CNT)) ? LOCKED : ACQ;
            end
            LOCKED: begin
               w_state_nxt = w_match ? LOCKED : ACQ;
               w_good_nxt  = w_match ? r_good : '0;
               w_err_inc   = !w_match;
            end
            default: w_state_nxt = UNLOCK;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= UNLOCK;
         r_good  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
      end
   end

   // r_have marks that a previous edge exists, so the next edge yields a real interval
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         half_period  <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         err_cnt      <= '0;
         r_cnt        <= '0;
         r_have       <= 1'b0;
      end else begin
         rise_pulse <= w_edge & w_level;
         fall_pulse <= w_edge & ~w_level;
         timeout    <= w_tmo;
         locked     <= r_state == LOCKED;
         r_cnt      <= w_edge ? '0 : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
         if (w_edge) r_have <= 1'b1;
         if (w_edge && r_have) begin
            half_period  <= w_meas[CNT_W-1:0];
            period_valid <= 1'b1;
         end
         if (w_tmo) begin
            r_have       <= 1'b0;
            period_valid <= 1'b0;
         end
         if (w_err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule
